// File: rtl/mips_fetch_if.sv
// Instruction-memory fetch channel: one word request per instruction,
// qualified by imem_ready while imem_req is high.
interface mips_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/mips_fetch.sv
// Fetch stage of the MIPS single-cycle core: PC register, FETCH/EXEC
// sequencing against instruction memory, next-PC commit and retire counter.
module mips_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  mips_fetch_if.master        imem,
  output logic [31:0]         instr,
  output logic [5:0]          op_code,
  output logic                instr_valid,
  output logic [31:0]         pc,
  output logic [31:0]         pc_plus4,
  input  logic                jump,
  input  logic                branch,
  input  logic                zero,
  input  logic                stall,
  output logic [31:0]         retired
);

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_EXEC  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retired_q, retired_d;

  logic [31:0] pc_plus4_w;
  logic [31:0] branch_off;
  logic [31:0] next_pc;

  assign pc_plus4_w = pc_q + 32'd4;
  assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // Jump outranks branch; all sources keep the low two bits at zero.
  always_comb begin
    if (jump) begin
      next_pc = {pc_plus4_w[31:28], instr_q[25:0], 2'b00};
    end else if (branch && zero) begin
      next_pc = pc_plus4_w + branch_off;
    end else begin
      next_pc = pc_plus4_w;
    end
  end

  always_comb begin
    // NOTE: every variable gets a hold default first so no path infers a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    unique case (state_q)
      S_FETCH: begin
        if (imem.imem_ready) begin
          instr_d = imem.imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          pc_d      = next_pc;
          retired_d = retired_q + 32'd1;
          state_d   = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC_ALIGNED;
      instr_q   <= 32'h0;
      retired_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  assign imem.imem_req  = (state_q == S_FETCH) && !rst;
  assign imem.imem_addr = pc_q;

  assign instr       = instr_q;
  assign op_code     = instr_q[31:26];
  assign instr_valid = (state_q == S_EXEC);
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_w;
  assign retired     = retired_q;

endmodule

// File: tb/tb_mips_fetch.sv
// Directed bench for mips_fetch: a per-cycle vector table on one instance,
// plus hand sequences for reset-in-fetch and jump on a high-region PC.
module tb_mips_fetch;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance A: RESET_PC = 0x40
  logic        a_rst, a_jump, a_branch, a_zero, a_stall;
  logic [31:0] a_instr, a_pc, a_pc_plus4, a_retired;
  logic [5:0]  a_op_code;
  logic        a_instr_valid;
  mips_fetch_if a_bus ();

  mips_fetch #(.RESET_PC(32'h0000_0040)) u_dut_a (
    .clk         (clk),
    .rst         (a_rst),
    .imem        (a_bus),
    .instr       (a_instr),
    .op_code     (a_op_code),
    .instr_valid (a_instr_valid),
    .pc          (a_pc),
    .pc_plus4    (a_pc_plus4),
    .jump        (a_jump),
    .branch      (a_branch),
    .zero        (a_zero),
    .stall       (a_stall),
    .retired     (a_retired)
  );

  // Instance B: unaligned reset value, high PC region
  logic        b_rst, b_jump, b_branch, b_zero, b_stall;
  logic [31:0] b_instr, b_pc, b_pc_plus4, b_retired;
  logic [5:0]  b_op_code;
  logic        b_instr_valid;
  mips_fetch_if b_bus ();

  mips_fetch #(.RESET_PC(32'h1000_0003)) u_dut_b (
    .clk         (clk),
    .rst         (b_rst),
    .imem        (b_bus),
    .instr       (b_instr),
    .op_code     (b_op_code),
    .instr_valid (b_instr_valid),
    .pc          (b_pc),
    .pc_plus4    (b_pc_plus4),
    .jump        (b_jump),
    .branch      (b_branch),
    .zero        (b_zero),
    .stall       (b_stall),
    .retired     (b_retired)
  );

  typedef struct {
    logic        rdy;
    logic [31:0] rdata;
    logic        j, b, z, st;
    logic        exp_req;
    logic [31:0] exp_pc;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_ret;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs [NV];

  localparam logic [31:0] W0  = 32'h2001_0001;
  localparam logic [31:0] W1  = 32'h2002_0002;
  localparam logic [31:0] W2  = 32'h2003_0003;
  localparam logic [31:0] JW  = 32'h0800_0040;  // jump -> 0x100
  localparam logic [31:0] JZ  = 32'h0800_0000;  // jump -> 0x0
  localparam logic [31:0] BW  = 32'h1000_FFFE;  // beq, offset -8 bytes
  localparam logic [31:0] J16 = 32'h0800_0010;  // jump -> {top,0x40}

  function automatic vec_t mk(input logic rdy, input logic [31:0] rdata,
                              input logic j, input logic b, input logic z,
                              input logic st, input logic req,
                              input logic [31:0] pc, input logic valid,
                              input logic [31:0] ins, input logic [31:0] ret);
    vec_t v;
    v.rdy = rdy; v.rdata = rdata; v.j = j; v.b = b; v.z = z; v.st = st;
    v.exp_req = req; v.exp_pc = pc; v.exp_valid = valid;
    v.exp_instr = ins; v.exp_ret = ret;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rdy rdata j  b  z  st  req pc            vld instr ret
    vecs[0]  = mk(1, W0,    0, 0, 0, 0,  1, 32'h40,       0,  32'h0, 0);
    vecs[1]  = mk(0, 0,     0, 0, 0, 0,  0, 32'h40,       1,  W0,    0);
    vecs[2]  = mk(1, W1,    0, 0, 0, 0,  1, 32'h44,       0,  W0,    1);
    vecs[3]  = mk(0, 0,     0, 0, 0, 0,  0, 32'h44,       1,  W1,    1);
    vecs[4]  = mk(1, W2,    0, 0, 0, 0,  1, 32'h48,       0,  W1,    2);
    vecs[5]  = mk(0, 0,     0, 0, 0, 0,  0, 32'h48,       1,  W2,    2);
    vecs[6]  = mk(0, W0,    0, 0, 0, 0,  1, 32'h4C,       0,  W2,    3);
    vecs[7]  = mk(0, W0,    0, 0, 0, 0,  1, 32'h4C,       0,  W2,    3);
    vecs[8]  = mk(0, W0,    0, 0, 0, 0,  1, 32'h4C,       0,  W2,    3);
    vecs[9]  = mk(1, JW,    0, 0, 0, 0,  1, 32'h4C,       0,  W2,    3);
    vecs[10] = mk(0, 0,     1, 0, 0, 0,  0, 32'h4C,       1,  JW,    3);
    vecs[11] = mk(1, BW,    1, 1, 1, 0,  1, 32'h100,      0,  JW,    4);
    vecs[12] = mk(0, 0,     0, 1, 1, 0,  0, 32'h100,      1,  BW,    4);
    vecs[13] = mk(1, W0,    0, 0, 0, 0,  1, 32'hFC,       0,  BW,    5);
    vecs[14] = mk(0, 0,     0, 0, 0, 0,  0, 32'hFC,       1,  W0,    5);
    vecs[15] = mk(1, BW,    0, 0, 0, 0,  1, 32'h100,      0,  W0,    6);
    vecs[16] = mk(0, 0,     0, 1, 0, 0,  0, 32'h100,      1,  BW,    6);
    vecs[17] = mk(1, W1,    0, 0, 0, 0,  1, 32'h104,      0,  BW,    7);
    vecs[18] = mk(0, 0,     1, 0, 0, 1,  0, 32'h104,      1,  W1,    7);
    vecs[19] = mk(1, W2,    0, 1, 1, 1,  0, 32'h104,      1,  W1,    7);
    vecs[20] = mk(0, 0,     0, 0, 0, 1,  0, 32'h104,      1,  W1,    7);
    vecs[21] = mk(0, 0,     0, 0, 0, 1,  0, 32'h104,      1,  W1,    7);
    vecs[22] = mk(0, 0,     0, 0, 0, 0,  0, 32'h104,      1,  W1,    7);
    vecs[23] = mk(1, JZ,    0, 0, 0, 0,  1, 32'h108,      0,  W1,    8);
    vecs[24] = mk(0, 0,     1, 1, 1, 0,  0, 32'h108,      1,  JZ,    8);
    vecs[25] = mk(1, BW,    0, 0, 0, 0,  1, 32'h0,        0,  JZ,    9);
    vecs[26] = mk(0, 0,     0, 1, 1, 0,  0, 32'h0,        1,  BW,    9);
    vecs[27] = mk(1, W0,    0, 0, 0, 0,  1, 32'hFFFF_FFFC, 0, BW,    10);
    vecs[28] = mk(0, 0,     0, 0, 0, 0,  0, 32'hFFFF_FFFC, 1, W0,    10);
    vecs[29] = mk(0, 0,     0, 0, 0, 0,  1, 32'h0,        0,  W0,    11);

    a_rst = 1'b1; a_jump = 1'b0; a_branch = 1'b0; a_zero = 1'b0; a_stall = 1'b0;
    a_bus.imem_ready = 1'b1; a_bus.imem_rdata = W2;
    b_rst = 1'b1; b_jump = 1'b0; b_branch = 1'b0; b_zero = 1'b0; b_stall = 1'b0;
    b_bus.imem_ready = 1'b0; b_bus.imem_rdata = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst.req", {31'h0, a_bus.imem_req}, 32'h0);
    check("rst.pc", a_pc, 32'h40);
    check("rst.instr", a_instr, 32'h0);
    check("rst.retired", a_retired, 32'h0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      a_rst = 1'b0;
      a_bus.imem_ready = vecs[i].rdy;
      a_bus.imem_rdata = vecs[i].rdata;
      a_jump = vecs[i].j; a_branch = vecs[i].b; a_zero = vecs[i].z;
      a_stall = vecs[i].st;
      #1;
      check($sformatf("v%0d.req", i), {31'h0, a_bus.imem_req}, {31'h0, vecs[i].exp_req});
      check($sformatf("v%0d.addr", i), a_bus.imem_addr, vecs[i].exp_pc);
      check($sformatf("v%0d.pc", i), a_pc, vecs[i].exp_pc);
      check($sformatf("v%0d.pc_plus4", i), a_pc_plus4, vecs[i].exp_pc + 32'd4);
      check($sformatf("v%0d.valid", i), {31'h0, a_instr_valid}, {31'h0, vecs[i].exp_valid});
      check($sformatf("v%0d.instr", i), a_instr, vecs[i].exp_instr);
      check($sformatf("v%0d.op_code", i), {26'h0, a_op_code}, {26'h0, vecs[i].exp_instr[31:26]});
      check($sformatf("v%0d.retired", i), a_retired, vecs[i].exp_ret);
    end

    // Reset pulse during FETCH with a ready word on the bus
    @(negedge clk);
    a_rst = 1'b1; a_bus.imem_ready = 1'b1; a_bus.imem_rdata = W2;
    a_jump = 1'b0; a_branch = 1'b0; a_zero = 1'b0; a_stall = 1'b0;
    #1;
    check("rstp.req_in_rst", {31'h0, a_bus.imem_req}, 32'h0);
    @(negedge clk);
    a_rst = 1'b0; a_bus.imem_ready = 1'b0;
    #1;
    check("rstp.pc", a_pc, 32'h40);
    check("rstp.instr", a_instr, 32'h0);
    check("rstp.retired", a_retired, 32'h0);
    check("rstp.valid", {31'h0, a_instr_valid}, 32'h0);
    check("rstp.req", {31'h0, a_bus.imem_req}, 32'h1);

    // Instance B: reset low bits forced, jump in the 0x1xxx_xxxx region
    @(negedge clk);
    b_rst = 1'b0; b_bus.imem_ready = 1'b1; b_bus.imem_rdata = J16;
    #1;
    check("b.reset_pc", b_pc, 32'h1000_0000);
    check("b.addr0", b_bus.imem_addr, 32'h1000_0000);
    check("b.req0", {31'h0, b_bus.imem_req}, 32'h1);
    @(negedge clk);
    b_bus.imem_ready = 1'b0; b_jump = 1'b1;
    #1;
    check("b.instr", b_instr, J16);
    check("b.valid", {31'h0, b_instr_valid}, 32'h1);
    @(negedge clk);
    b_jump = 1'b0; b_bus.imem_ready = 1'b1;
    #1;
    check("b.jump_addr", b_bus.imem_addr, 32'h1000_0040);
    @(negedge clk);
    b_bus.imem_ready = 1'b0; b_jump = 1'b1; b_branch = 1'b1; b_zero = 1'b1;
    #1;
    check("b.valid2", {31'h0, b_instr_valid}, 32'h1);
    @(negedge clk);
    b_jump = 1'b0; b_branch = 1'b0; b_zero = 1'b0;
    #1;
    check("b.jump_wins_addr", b_bus.imem_addr, 32'h1000_0040);
    check("b.retired", b_retired, 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_fetch.md
# mips_fetch

Instruction-fetch stage for the MIPS single-cycle core. Holds the program counter, requests one instruction word per instruction from instruction memory over a req/ready handshake, latches it, and presents it (and its op_code field) to the main decoder and datapath. At the end of each execute cycle it commits the next PC from the decoder's `jump`/`branch` and the ALU `zero` flag, and counts retired instructions.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] are forced to 0.
- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; high only in FETCH and only while rst=0.
- imem_addr  out  32  byte address of the word requested; equals pc.
- imem_ready  in  1  memory has valid imem_rdata this cycle; sampled only while imem_req=1.
- imem_rdata  in  32  instruction word.
- instr  out  32  latched instruction.
- op_code  out  6  instr[31:26], to the main decoder.
- instr_valid  out  1  high while in EXEC, meaning instr is executing.
- pc  out  32  address of the current instruction.
- pc_plus4  out  32  pc + 4, modulo 2^32.
- jump  in  1  from the main decoder.
- branch  in  1  from the main decoder.
- zero  in  1  ALU zero flag.
- stall  in  1  holds EXEC; PC and instr are frozen.
- retired  out  32  count of committed instructions.

## Operation
- FSM has two states, FETCH and EXEC.
- FETCH:
  - imem_req=1, imem_addr=pc, instr_valid=0.
  - When imem_ready=1: instr<=imem_rdata at the edge and the FSM moves to EXEC.
  - When imem_ready=0: the FSM stays in FETCH and pc and instr are held.
- EXEC:
  - instr_valid=1 and imem_req=0.
  - If stall=1, the FSM stays in EXEC with all state held.
  - If stall=0, at the edge: pc<=next_pc, retired<=retired+1, FSM->FETCH.
- next_pc priority:
  1. jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}.
  2. Else branch&zero: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}).
  3. Else pc_plus4.
- Arithmetic and counter rules:
  - All PC arithmetic is 32-bit and wraps modulo 2^32; 32'hFFFF_FFFC + 4 = 0.
  - The branch offset is sign-extended, so negative offsets go backward.
  - retired wraps from 32'hFFFF_FFFF to 0.
- pc[1:0] is always 00, because every next_pc source has zero low bits and the RESET_PC low bits are forced.
- jump, branch and zero are sampled only in the EXEC cycle where stall=0. Their values in FETCH or during stall are ignored.
- Reset (rst=1 at an edge) loads pc=RESET_PC&~3, instr=0, retired=0 and state=FETCH. This works from either state. An outstanding fetch is abandoned, and an imem_ready in the reset cycle is ignored.

## Timing
- Values while rst is high and after the reset edge:
  - imem_req=0 while rst=1.
  - After the reset edge: imem_req=1, imem_addr=RESET_PC, instr=0, op_code=0, instr_valid=0, pc=RESET_PC, pc_plus4=RESET_PC+4, retired=0.
- Fetch latency:
  - With an imem_ready=1 cycle at edge N, instr and instr_valid=1 are visible after edge N.
  - The minimum is 2 cycles per instruction: 1 FETCH + 1 EXEC. Each memory wait cycle adds 1.
- imem_addr is stable for the whole of FETCH, including wait cycles.
- op_code, pc and pc_plus4 are stable for the whole of EXEC, including stall cycles.
- next_pc is combinational from registered state plus jump/branch/zero. The decoder and ALU round trip fits in the EXEC cycle.

## Test plan
- Reset with RESET_PC=32'h0000_0040, imem_ready always 1, memory of non-branch words:
  - imem_addr sequence is 0x40, 0x44, 0x48, with instr_valid high every 2nd cycle.
  - retired reads 3 after 6 cycles.
- Memory wait states, imem_ready low for 3 cycles then high:
  - imem_req stays high for 4 cycles with a constant imem_addr.
  - instr_valid rises the cycle after ready.
- Branch taken at pc=0x100, instr[15:0]=16'hFFFE, branch=1, zero=1: next imem_addr is 0xFC. With zero=0 it is 0x104.
- Jump at pc=0x1000_0000 with instr[25:0]=26'h000_0010:
  - next imem_addr is 0x1000_0040.
  - The same applies when branch=zero=1 at the same time, because jump wins.
- stall=1 for 4 EXEC cycles:
  - instr_valid, pc and instr are held.
  - retired increments only once, after stall falls.
- Reset pulse in FETCH while imem_ready=1:
  - The word is not latched.
  - pc=RESET_PC, retired=0 and imem_req=0 during the rst cycle.
- Wrap-around with pc=32'hFFFF_FFFC and no branch: next pc is 0.
